// File: rtl/pat_det_arb_pkg.sv
// -----------------------------------------------------------------------------
// pat_det_arb_pkg
//   Shared types and constants for the round-robin pattern-detect arbiter.
//   - arb_state_t : arbiter FSM states (IDLE -> RUN -> FLUSH -> IDLE)
//   - det_state_t : one-hot detector states, named after the prefix matched
//   - PATTERN     : detected bit sequence, MSB is the first bit received
// -----------------------------------------------------------------------------
package pat_det_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } arb_state_t;

    typedef enum logic [5:0] {
        DS_RST  = 6'b000001,
        DS_1    = 6'b000010,
        DS_10   = 6'b000100,
        DS_101  = 6'b001000,
        DS_1011 = 6'b010000,
        DS_DET  = 6'b100000
    } det_state_t;

    localparam logic [4:0] PATTERN = 5'b10110;

endpackage

// File: rtl/pat_det_core.sv
// -----------------------------------------------------------------------------
// pat_det_core
//   Moore, non-overlapping detector for PATTERN (1-0-1-1-0, first bit first).
//   Ports:
//     clk_i   in  clock, rising edge
//     rst_i   in  synchronous active-high reset
//     clr_i   in  synchronous clear back to the idle state
//     in_i    in  serial data bit
//     valid_i in  qualifies in_i; low cycles hold the state
//     det_o   out high for the single cycle spent in DS_DET
// -----------------------------------------------------------------------------
module pat_det_core
    import pat_det_arb_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic in_i,
    input  logic valid_i,
    output logic det_o
);

    det_state_t r_state;
    det_state_t w_next;

    // NOTE: w_next gets a default before the case so every path assigns it
    // and no latch is inferred; the default also recovers illegal encodings.
    always_comb begin
        w_next = DS_RST;
        case (r_state)
            // DS_DET always leaves after one cycle and restarts from idle,
            // which is what makes the detector non-overlapping.
            DS_RST, DS_DET: if (valid_i && in_i == PATTERN[4]) w_next = DS_1;
            DS_1:    w_next = !valid_i ? DS_1    : (in_i == PATTERN[3]) ? DS_10   : DS_1;
            DS_10:   w_next = !valid_i ? DS_10   : (in_i == PATTERN[2]) ? DS_101  : DS_RST;
            DS_101:  w_next = !valid_i ? DS_101  : (in_i == PATTERN[1]) ? DS_1011 : DS_10;
            DS_1011: w_next = !valid_i ? DS_1011 : (in_i == PATTERN[0]) ? DS_DET  : DS_1;
            default: w_next = DS_RST;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) r_state <= DS_RST;
        else                r_state <= w_next;
    end

    assign det_o = (r_state == DS_DET);

endmodule

// File: rtl/pat_det_arb.sv
// -----------------------------------------------------------------------------
// pat_det_arb
//   Round-robin arbiter granting one serial channel at a time to a shared
//   1-0-1-1-0 pattern detector. A frame is FRAME_LEN accepted bits; dropping
//   the granted request aborts the frame. Every frame ends with one FLUSH
//   cycle that clears the detector and advances the round-robin pointer.
//   Optional per-channel saturating detection counters are built when the
//   macro PAT_DET_ARB_STATS_EN is defined; otherwise count_o is tied to 0.
//   Ports:
//     clk_i        in  clock, rising edge
//     rst_i        in  synchronous active-high reset
//     req_i        in  [N_REQ]  per-channel request, held for the frame
//     in_i         in  [N_REQ]  per-channel serial data
//     valid_i      in  [N_REQ]  per-channel bit qualifier
//     gnt_o        out [N_REQ]  one-hot grant (registered)
//     det_o        out          one-cycle detection pulse
//     det_ch_o     out [clog2]  channel that produced det_o
//     frame_done_o out          one-cycle pulse in FLUSH of a completed frame
//     busy_o       out          high in RUN and FLUSH
//     count_o      out [N_REQ*CNT_W] per-channel detection counts, ch0 in LSBs
// -----------------------------------------------------------------------------
module pat_det_arb
    import pat_det_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int FRAME_LEN = 16,
    parameter int CNT_W     = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [N_REQ-1:0]           req_i,
    input  logic [N_REQ-1:0]           in_i,
    input  logic [N_REQ-1:0]           valid_i,
    output logic [N_REQ-1:0]           gnt_o,
    output logic                       det_o,
    output logic [$clog2(N_REQ)-1:0]   det_ch_o,
    output logic                       frame_done_o,
    output logic                       busy_o,
    output logic [N_REQ*CNT_W-1:0]     count_o
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int BC_W  = $clog2(FRAME_LEN + 1);

    arb_state_t       r_state;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [IDX_W-1:0] r_gnt_idx;
    logic [BC_W-1:0]  r_bit_cnt;
    logic [N_REQ-1:0] r_gnt;
    logic             r_frame_done;
    logic             r_busy;

    logic             w_req_g;
    logic             w_bit_ok;
    logic             w_clr;
    logic             w_det;
    logic [IDX_W-1:0] w_pick;

    // First requester at or after ptr, wrapping. Walking k downwards lets
    // the smallest offset overwrite the result last.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                 input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] sel;
        int               idx;
        sel = ptr;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (req[idx]) sel = IDX_W'(idx);
        end
        return sel;
    endfunction

    assign w_pick   = rr_pick(req_i, r_rr_ptr);
    assign w_req_g  = req_i[r_gnt_idx];
    // A bit arriving on the edge where the request drops is discarded.
    assign w_bit_ok = (r_state == ST_RUN) && w_req_g && valid_i[r_gnt_idx];
    assign w_clr    = (r_state == ST_FLUSH);

    pat_det_core u_core (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (w_clr),
        .in_i    (in_i[r_gnt_idx]),
        .valid_i (w_bit_ok),
        .det_o   (w_det)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= ST_IDLE;
            r_rr_ptr     <= '0;
            r_gnt_idx    <= '0;
            r_bit_cnt    <= '0;
            r_gnt        <= '0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (|req_i) begin
                        r_gnt_idx <= w_pick;
                        r_gnt     <= N_REQ'(1) << w_pick;
                        r_bit_cnt <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!w_req_g) begin
                        r_gnt     <= '0;
                        r_bit_cnt <= '0;
                        r_state   <= ST_FLUSH;
                    end else if (w_bit_ok) begin
                        if (r_bit_cnt == BC_W'(FRAME_LEN - 1)) begin
                            r_gnt        <= '0;
                            r_bit_cnt    <= '0;
                            r_frame_done <= 1'b1;
                            r_state      <= ST_FLUSH;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BC_W'(1);
                        end
                    end
                end
                ST_FLUSH: begin
                    r_busy   <= 1'b0;
                    r_rr_ptr <= (r_gnt_idx == IDX_W'(N_REQ - 1)) ? '0
                                                                 : r_gnt_idx + IDX_W'(1);
                    r_state  <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign gnt_o        = r_gnt;
    assign det_o        = w_det;
    // r_gnt_idx is only updated on a new grant, so it still names the
    // channel during the FLUSH cycle where a final-bit detection shows up.
    assign det_ch_o     = r_gnt_idx;
    assign frame_done_o = r_frame_done;
    assign busy_o       = r_busy;

`ifdef PAT_DET_ARB_STATS_EN
    logic [N_REQ*CNT_W-1:0] r_count;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_count <= '0;
        end else if (w_det) begin
            for (int c = 0; c < N_REQ; c++) begin
                if (r_gnt_idx == IDX_W'(c) &&
                    r_count[c*CNT_W +: CNT_W] != {CNT_W{1'b1}}) begin
                    r_count[c*CNT_W +: CNT_W] <= r_count[c*CNT_W +: CNT_W] + CNT_W'(1);
                end
            end
        end
    end

    assign count_o = r_count;
`else
    assign count_o = '0;
`endif

endmodule

// File: tb/tb_pat_det_arb.sv
// -----------------------------------------------------------------------------
// tb_pat_det_arb
//   Directed scoreboard bench for pat_det_arb (N_REQ=4, FRAME_LEN=16,
//   CNT_W=2). Stimulus pushes expected grants, detections and frame-done
//   events into queues; a negedge monitor pops and compares them whenever the
//   DUT presents the corresponding output.
// -----------------------------------------------------------------------------
module tb_pat_det_arb;

    localparam int N  = 4;
    localparam int FL = 16;
    localparam int CW = 2;

    logic             clk = 1'b0;
    logic             rst_i;
    logic [N-1:0]     req_i;
    logic [N-1:0]     in_i;
    logic [N-1:0]     valid_i;
    logic [N-1:0]     gnt_o;
    logic             det_o;
    logic [1:0]       det_ch_o;
    logic             frame_done_o;
    logic             busy_o;
    logic [N*CW-1:0]  count_o;

    pat_det_arb #(.N_REQ(N), .FRAME_LEN(FL), .CNT_W(CW)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .req_i        (req_i),
        .in_i         (in_i),
        .valid_i      (valid_i),
        .gnt_o        (gnt_o),
        .det_o        (det_o),
        .det_ch_o     (det_ch_o),
        .frame_done_o (frame_done_o),
        .busy_o       (busy_o),
        .count_o      (count_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int ch;
        bit in_flush;
    } det_exp_t;

    logic [N-1:0] q_gnt[$];
    det_exp_t     q_det[$];
    int           q_done[$];
    int           cnt_model[N];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event missing or unexpected", name);
    endtask

    function automatic logic [N*CW-1:0] count_exp();
        logic [N*CW-1:0] r;
        r = '0;
`ifdef PAT_DET_ARB_STATS_EN
        for (int c = 0; c < N; c++) r[c*CW +: CW] = CW'(cnt_model[c]);
`endif
        return r;
    endfunction

    task automatic push_gnt(input int ch);
        q_gnt.push_back(N'(1) << ch);
    endtask

    task automatic push_det(input int ch, input bit in_flush);
        det_exp_t e;
        e.ch = ch;
        e.in_flush = in_flush;
        q_det.push_back(e);
        if (cnt_model[ch] < (1 << CW) - 1) cnt_model[ch]++;
    endtask

    task automatic push_done(input int ch);
        q_done.push_back(ch);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (gnt_o == '0 && cyc < 40);
        if (gnt_o == '0) fail_now("grant_timeout");
    endtask

    // Granted channel gets `bits` MSB first; the others get valid noise that
    // contains the pattern, which must be ignored. With gaps, every bit is
    // followed by an invalid cycle carrying the inverted bit.
    task automatic drive_bits(input logic [63:0] bits, input int n,
                              input logic [N-1:0] mask, input bit gaps);
        logic [4:0] nz;
        logic       b;
        nz = 5'b10110;
        for (int i = 0; i < n; i++) begin
            b = bits[n-1-i];
            for (int c = 0; c < N; c++) in_i[c] = mask[c] ? b : nz[(i + c) % 5];
            valid_i = '1;
            tick();
            if (gaps) begin
                for (int c = 0; c < N; c++) if (mask[c]) in_i[c] = ~b;
                valid_i = ~mask;
                tick();
            end
        end
        valid_i = '0;
        in_i    = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"},   64'(gnt_o),        64'd0);
        check({tag, "_det"},   64'(det_o),        64'd0);
        check({tag, "_detch"}, 64'(det_ch_o),     64'd0);
        check({tag, "_done"},  64'(frame_done_o), 64'd0);
        check({tag, "_busy"},  64'(busy_o),       64'd0);
        check({tag, "_count"}, 64'(count_o),      64'd0);
    endtask

    // Monitor
    logic [N-1:0] prev_gnt;
    logic         prev_busy;
    int           flush_len;
    int           last_ch;
    det_exp_t     de;

    always @(negedge clk) begin
        if (rst_i) begin
            prev_gnt  = '0;
            prev_busy = 1'b0;
            flush_len = 0;
        end else begin
            if (gnt_o != '0 && prev_gnt == '0) begin
                if (q_gnt.size() == 0) fail_now("gnt_unexpected");
                else check("gnt", 64'(gnt_o), 64'(q_gnt.pop_front()));
                for (int c = 0; c < N; c++) if (gnt_o[c]) last_ch = c;
            end
            if (det_o) begin
                if (q_det.size() == 0) fail_now("det_unexpected");
                else begin
                    de = q_det.pop_front();
                    check("det_ch", 64'(det_ch_o), 64'(de.ch));
                    check("det_in_flush", 64'(busy_o && gnt_o == '0), 64'(de.in_flush));
                end
            end
            if (frame_done_o) begin
                if (q_done.size() == 0) fail_now("done_unexpected");
                else begin
                    check("done_ch", 64'(last_ch), 64'(q_done.pop_front()));
                    check("done_in_flush", 64'(busy_o && gnt_o == '0), 64'd1);
                end
            end
            if (busy_o && gnt_o == '0) flush_len++;
            if (!busy_o && prev_busy) begin
                check("flush_len", 64'(flush_len), 64'd1);
                flush_len = 0;
            end
            prev_gnt  = gnt_o;
            prev_busy = busy_o;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        for (int c = 0; c < N; c++) cnt_model[c] = 0;
        rst_i = 1'b1; req_i = '0; in_i = '0; valid_i = '0;
        tick(); tick();
        check_all_zero("reset");
        rst_i = 1'b0;

        // Single channel, pattern at the start of the frame.
        req_i = 4'b0001;
        push_gnt(0); push_det(0, 1'b0); push_done(0);
        wait_grant(cyc);
        check("gnt_latency", 64'(cyc), 64'd1);
        drive_bits(64'hB000, 16, 4'b0001, 1'b0);
        req_i = '0;
        tick(); tick(); tick();
        check("count_a", 64'(count_o), 64'(count_exp()));

        // Non-overlap stream 1,0,1,1,0,1,1,0 with invalid gap cycles.
        req_i = 4'b0010;
        push_gnt(1); push_det(1, 1'b0); push_done(1);
        wait_grant(cyc);
        drive_bits(64'hB600, 16, 4'b0010, 1'b1);
        req_i = '0;
        tick(); tick(); tick();
        check("count_b", 64'(count_o), 64'(count_exp()));

        // No detection across frames; detection on the final bit of a frame.
        req_i = 4'b0100;
        push_gnt(2); push_done(2);
        push_gnt(2); push_done(2);
        push_gnt(2); push_done(2); push_det(2, 1'b1);
        wait_grant(cyc);
        drive_bits(64'h000B, 16, 4'b0100, 1'b0);
        wait_grant(cyc);
        drive_bits(64'h0000, 16, 4'b0100, 1'b0);
        wait_grant(cyc);
        drive_bits(64'h0016, 16, 4'b0100, 1'b0);
        req_i = '0;
        tick(); tick(); tick();
        check("count_c", 64'(count_o), 64'(count_exp()));

        // Reset in the middle of a frame, on the edge completing the pattern.
        req_i = 4'b0001;
        push_gnt(0);
        wait_grant(cyc);
        drive_bits(64'hB, 4, 4'b0001, 1'b0);
        in_i = '0; valid_i = '1; rst_i = 1'b1;
        tick();
        check_all_zero("midrst");
        for (int c = 0; c < N; c++) cnt_model[c] = 0;
        rst_i = 1'b0; req_i = '0; valid_i = '0;
        tick(); tick(); tick();
        check("midrst_busy_after", 64'(busy_o), 64'd0);

        // All channels requesting: grants rotate 0,1,2,3,0.
        req_i = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            push_gnt(k % N); push_done(k % N);
        end
        for (int k = 0; k < 5; k++) begin
            wait_grant(cyc);
            drive_bits(64'h0000, 16, N'(1) << (k % N), 1'b0);
        end
        req_i = 4'b1100;

        // Channel 2 aborts after 8 bits; the pattern-completing bit on the
        // abort edge is discarded, and channel 3 is granted next.
        push_gnt(2);
        wait_grant(cyc);
        drive_bits(64'h0B, 8, 4'b0100, 1'b0);
        req_i = 4'b1000; in_i = '0; valid_i = '1;
        tick();
        valid_i = '0;
        push_gnt(3); push_det(3, 1'b0); push_done(3);
        wait_grant(cyc);
        drive_bits(64'hB000, 16, 4'b1000, 1'b0);
        req_i = '0;
        tick(); tick(); tick();
        check("count_f", 64'(count_o), 64'(count_exp()));

        // Five detections on channel 1 saturate a 2-bit counter at 3.
        req_i = 4'b0010;
        push_gnt(1); push_det(1, 1'b0); push_det(1, 1'b0); push_det(1, 1'b0); push_done(1);
        push_gnt(1); push_det(1, 1'b0); push_det(1, 1'b0); push_done(1);
        wait_grant(cyc);
        drive_bits(64'hB5AC, 16, 4'b0010, 1'b0);
        wait_grant(cyc);
        drive_bits(64'hB580, 16, 4'b0010, 1'b0);
        req_i = '0;
        tick(); tick(); tick();
        check("count_g", 64'(count_o), 64'(count_exp()));

        check("q_gnt_left",  64'(q_gnt.size()),  64'd0);
        check("q_det_left",  64'(q_det.size()),  64'd0);
        check("q_done_left", 64'(q_done.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pat_det_arb.md
PAT_DET_ARB -- requirements
Module: pat_det_arb

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesting serial channels (2..8).
REQ-002 SHALL have parameter FRAME_LEN, default 16, valid bits per granted frame (>=5).
REQ-003 SHALL have parameter CNT_W, default 8, width of each per-channel detection counter.
REQ-004 SHALL have port clk_i, input, 1, sole clock, rising edge.
REQ-005 SHALL have port rst_i, input, 1, reset; synchronous, active-high.
REQ-006 SHALL have port req_i, input, N_REQ, per-channel request, level, held for the whole frame.
REQ-007 SHALL have port in_i, input, N_REQ, per-channel serial data bit.
REQ-008 SHALL have port valid_i, input, N_REQ, per-channel bit-valid qualifier.
REQ-009 SHALL have port gnt_o, output, N_REQ, one-hot grant, registered.
REQ-010 SHALL have port det_o, output, 1, one-cycle pattern-detected pulse.
REQ-011 SHALL have port det_ch_o, output, clog2(N_REQ), channel index qualifying det_o.
REQ-012 SHALL have port frame_done_o, output, 1, one-cycle pulse on a completed (non-aborted) frame.
REQ-013 SHALL have port busy_o, output, 1, high in RUN and FLUSH.
REQ-014 SHALL have port count_o, output, N_REQ*CNT_W, packed per-channel detection counts, channel 0 in LSBs.

Function
REQ-015 SHALL share one Moore non-overlapping detector for pattern 1-0-1-1-0 (first bit first) among all channels.
REQ-016 SHALL implement the FSM IDLE -> RUN -> FLUSH -> IDLE.
REQ-017 IDLE: if any req_i bit is set, SHALL select the first requester at or after rr_ptr (round-robin, wrapping from N_REQ-1 to 0), assert its gnt_o bit from the next cycle, and enter RUN.
REQ-018 RUN: SHALL feed in_i of the granted channel to the detector only in cycles where that channel's valid_i is high; ungranted in_i and valid_i SHALL be ignored.
REQ-019 RUN: SHALL count accepted bits; the edge accepting bit FRAME_LEN SHALL move the FSM to FLUSH and set frame_done_o high for the FLUSH cycle.
REQ-020 RUN: if the granted req_i bit drops, SHALL abort to FLUSH with no frame_done_o; any bit accepted on that edge is discarded.
REQ-021 FLUSH: SHALL last exactly one cycle, deassert gnt_o, clear the detector to its idle state, and set rr_ptr to granted index + 1 (modulo N_REQ).
REQ-022 det_o SHALL be high for exactly the one cycle after the edge accepting the final 0 of the pattern; the detector SHALL then restart from idle (no overlap).
REQ-023 A detection completed by the last bit of a frame SHALL pulse det_o during FLUSH with the correct det_ch_o, and SHALL be counted.
REQ-024 Patterns SHALL never span frames or channels.
REQ-025 det_ch_o SHALL equal the granted index whenever det_o is high; otherwise its value is don't-care.
REQ-026 Each count_o field SHALL increment on its channel's det_o and saturate at 2^CNT_W-1.
REQ-027 valid_i low cycles SHALL leave the detector state and bit counter unchanged.

Reset
REQ-028 On rst_i high at a clock edge: FSM=IDLE, rr_ptr=0, detector idle, bit counter=0, and all outputs (gnt_o, det_o, det_ch_o, frame_done_o, busy_o, count_o)=0.
REQ-029 Reset asserted mid-frame SHALL override all other events; no det_o or frame_done_o SHALL be produced for the interrupted frame.

Configuration
REQ-030 With macro PAT_DET_ARB_STATS_EN defined, per-channel counters per REQ-026 SHALL be built.
REQ-031 Without PAT_DET_ARB_STATS_EN, no counter flops SHALL exist and count_o SHALL be constant 0; all other behaviour SHALL be unchanged.

Structure
REQ-032 Package pat_det_arb_pkg SHALL hold the FSM state enum, the detector state encoding (one-hot: reset, 1, 10, 101, 1011, detect), and the pattern constant 5'b10110.
REQ-033 The detector SHALL be a sub-module pat_det_core (clk_i, rst_i, clr_i, in_i, valid_i, det_o); pat_det_arb instantiates one.

Verification
REQ-034 Reset, then req_i=4'b0001 with bits 1,0,1,1,0 then 11 zeros -> gnt_o=0001 one cycle after req; exactly one det_o with det_ch_o=0; frame_done_o once; count_o[7:0]=1.
REQ-035 Stream 1,0,1,1,0,1,1,0 -> one detection only (non-overlap), not two.
REQ-036 req_i=4'b1111 held through frames -> grants cycle 0,1,2,3,0, with one FLUSH cycle between frames.
REQ-037 Channel 2 drops req_i after 8 bits -> abort; no frame_done_o; next grant goes to channel 3.
REQ-038 Pattern 1,0,1,1 ends frame k and a 0 begins frame k+1 -> no det_o; pattern as last 5 bits of a frame -> det_o during FLUSH.
REQ-039 CNT_W=2, 5 detections on channel 1 -> count field reads 3; rst_i asserted mid-frame -> all outputs 0 on the next cycle.
